// File: rtl/wb_port_arbiter.sv
// Write-port arbiter: per-producer result FIFOs feeding NPORT register-file
// write ports in round-robin order, with a per-register pending mask.
module wb_port_arbiter #(
  parameter int NREQ  = 8,
  parameter int NPORT = 2,
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 interlock,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rt,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NPORT-1:0]     wr_en,
  output logic [NPORT*AW-1:0]  wr_addr,
  output logic [NPORT*DW-1:0]  wr_data,
  output logic [(2**AW)-1:0]   pending_mask,
  output logic                 busy
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW1 = RW + 1;
  localparam logic [CW-1:0]  FULL   = CW'(DEPTH);
  localparam logic [RW:0]    NREQ_W = RW1'(NREQ);
  localparam logic [RW-1:0]  LAST_I = RW'(NREQ - 1);

  logic [AW-1:0]   mem_rt   [NREQ][DEPTH];
  logic [DW-1:0]   mem_data [NREQ][DEPTH];
  logic [PW-1:0]   rd_ptr   [NREQ];
  logic [PW-1:0]   wr_ptr   [NREQ];
  logic [CW-1:0]   count    [NREQ];
  logic [RW-1:0]   rr;
  logic [RW-1:0]   rr_nxt;

  logic [AW-1:0]   head_rt   [NREQ];
  logic [DW-1:0]   head_data [NREQ];
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] gnt;
  logic [NPORT-1:0] sel_v;
  logic [AW-1:0]   sel_rt   [NPORT];
  logic [DW-1:0]   sel_data [NPORT];

  assign push = req_valid & req_ready;

  // FIFO heads and not-full flags, from registered state only
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      head_rt[i]   = mem_rt[i][rd_ptr[i]];
      head_data[i] = mem_data[i][rd_ptr[i]];
      req_ready[i] = (count[i] != FULL);
    end
  end

  // Round-robin scan from rr: first NPORT non-empty heads whose rt does not
  // clash with a head already granted this cycle
  always_comb begin
    logic [RW:0]   sum;
    logic [RW-1:0] idx;
    logic          collide;
    logic          placed;
    gnt     = '0;
    sel_v   = '0;
    rr_nxt  = rr;
    sum     = '0;
    idx     = '0;
    collide = 1'b0;
    placed  = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      sel_rt[p]   = '0;
      sel_data[p] = '0;
    end
    if (!interlock) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rr} + RW1'(k);
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        idx = sum[RW-1:0];
        collide = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
          if (sel_v[p] && (sel_rt[p] == head_rt[idx])) collide = 1'b1;
        end
        placed = 1'b0;
        if ((count[idx] != '0) && !collide) begin
          for (int p = 0; p < NPORT; p++) begin
            if (!placed && !sel_v[p]) begin
              sel_v[p]    = 1'b1;
              sel_rt[p]   = head_rt[idx];
              sel_data[p] = head_data[idx];
              placed      = 1'b1;
            end
          end
        end
        if (placed) begin
          gnt[idx] = 1'b1;
          rr_nxt   = (idx == LAST_I) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  // FIFO storage; validity is tracked by the counters, so no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        mem_rt[i][wr_ptr[i]]   <= req_rt[i*AW +: AW];
        mem_data[i][wr_ptr[i]] <= req_data[i*DW +: DW];
      end
    end
  end

  // FIFO pointers, occupancy and round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (gnt[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], gnt[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      rr <= rr_nxt;
    end
  end

  // Registered write ports: a grant this cycle is a one-cycle strobe next cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        wr_en[p]             <= sel_v[p];
        wr_addr[p*AW +: AW]  <= sel_rt[p];
        wr_data[p*DW +: DW]  <= sel_data[p];
      end
    end
  end

  // Pending mask: every queued entry plus every write on the ports right now
  always_comb begin
    logic [PW-1:0] slot;
    pending_mask = '0;
    slot         = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot = rd_ptr[i] + PW'(k);
        if (CW'(k) < count[i]) pending_mask[mem_rt[i][slot]] = 1'b1;
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      if (wr_en[p]) pending_mask[wr_addr[p*AW +: AW]] = 1'b1;
    end
  end

  // Busy while anything is queued or being written
  always_comb begin
    busy = |wr_en;
    for (int i = 0; i < NREQ; i++) begin
      if (count[i] != '0) busy = 1'b1;
    end
  end

endmodule
